// File: rtl/ahb_cmd_pkg.sv
// ahb_cmd_pkg: shared opcodes, sequencer states, command word layout and error-flag bit positions
package ahb_cmd_pkg;
   localparam logic [7:0] OP_WRITE = 8'hF0;
   localparam logic [7:0] OP_READ  = 8'hDE;
   localparam logic [7:0] OP_CLEAR = 8'hC1;
   typedef enum logic [2:0] {IDLE, WR_GO, WR_FILL, WR_WAIT, RD_GO, RD_DATA} state_t;
   typedef struct packed {
      logic [7:0]  op;
      logic [7:0]  len;
      logic [15:0] offset;
   } cmd_t;
   localparam int ERR_BADOP = 0;
   localparam int ERR_LEN   = 1;
   localparam int ERR_ABORT = 2;
endpackage

// File: rtl/ahb_cmd_sequencer_cmd_decode.sv
// cmd_decode: splits a command word into its fields and classifies it
// Ports: cmd_data (raw word in), cmd (decoded fields), valid (executable),
//        len_err (word count 0 or above MAX_WORDS), bad_op (unknown opcode)
module cmd_decode import ahb_cmd_pkg::*; #(
   parameter int MAX_WORDS = 64
) (
   input  logic [31:0] cmd_data,
   output cmd_t        cmd,
   output logic        valid,
   output logic        len_err,
   output logic        bad_op
);
   assign cmd     = cmd_t'(cmd_data);
   assign bad_op  = !(cmd.op inside {OP_WRITE, OP_READ, OP_CLEAR});
   // CLEAR carries no transfer, so its count field is not checked
   assign len_err = !bad_op && cmd.op != OP_CLEAR && (cmd.len == 8'd0 || int'(cmd.len) > MAX_WORDS);
   assign valid   = !bad_op && !len_err;
endmodule

// File: rtl/ahb_cmd_sequencer.sv
// ahb_cmd_sequencer: pops host commands and streams register-file words to the AHB write master or captures read-master words
// Ports: clk/reset_n (async active-low); data/data_addr register-file read port;
//        cmd_rd_en/cmd_data/cmd_empty show-ahead command FIFO; disp_sel/disp_addr/display_data display conduit;
//        write_* and read_* AHB master control and user-buffer handshakes; busy; err_flags sticky {abort, len_err, bad_op}.
// Build option: XFER_STATS_EN adds saturating write/read/abort counters shown at status addresses 1/2/3.
module ahb_cmd_sequencer import ahb_cmd_pkg::*; #(
   parameter int          ADDRESSWIDTH = 32,
   parameter int          DATAWIDTH    = 32,
   parameter int          NUMREGS      = 32,
   parameter int          MAX_WORDS    = 64,
   parameter logic [31:0] AHB_BASE     = 32'h0,
   parameter logic [31:0] REG_BASE     = 32'h2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [DATAWIDTH-1:0]         data,
   output logic [ADDRESSWIDTH-1:0]      data_addr,
   output logic                         cmd_rd_en,
   input  logic [31:0]                  cmd_data,
   input  logic                         cmd_empty,
   input  logic                         disp_sel,
   input  logic [$clog2(NUMREGS)-1:0]   disp_addr,
   output logic [DATAWIDTH-1:0]         display_data,
   output logic                         write_control_go,
   output logic                         write_control_fixed_location,
   output logic [ADDRESSWIDTH-1:0]      write_control_write_base,
   output logic [ADDRESSWIDTH-1:0]      write_control_write_length,
   output logic [2:0]                   write_data_size,
   input  logic                         write_control_done,
   input  logic                         write_abort,
   output logic                         write_user_write_buffer,
   output logic [DATAWIDTH-1:0]         write_user_buffer_data,
   input  logic                         write_user_buffer_full,
   output logic                         read_control_go,
   output logic                         read_control_fixed_location,
   output logic [ADDRESSWIDTH-1:0]      read_control_read_base,
   output logic [ADDRESSWIDTH-1:0]      read_control_read_length,
   output logic [2:0]                   read_data_size,
   input  logic                         read_control_done,
   input  logic                         read_abort,
   output logic                         read_user_read_buffer,
   input  logic [DATAWIDTH-1:0]         read_user_buffer_data,
   input  logic                         read_user_data_available,
   output logic                         busy,
   output logic [2:0]                   err_flags
);
   localparam int          BPW   = DATAWIDTH / 8;
   localparam int          IW    = $clog2(NUMREGS);
   localparam logic [2:0]  DSIZE = 3'($clog2(BPW));

   state_t                 state, state_nx;
   cmd_t                   cmd;
   logic                   valid, len_err, bad_op;
   logic                   push, pop, abort, accept, clr, done_seen;
   logic [7:0]             left;
   logic [IW-1:0]          idx;
   logic [DATAWIDTH-1:0]   cap [NUMREGS];
   logic [DATAWIDTH-1:0]   status;

   cmd_decode #(.MAX_WORDS(MAX_WORDS)) u_dec (
      .cmd_data(cmd_data),
      .cmd     (cmd),
      .valid   (valid),
      .len_err (len_err),
      .bad_op  (bad_op)
   );

   assign busy                         = state != IDLE;
   assign accept                       = cmd_rd_en && valid;
   assign clr                          = accept && cmd.op == OP_CLEAR;
   assign write_control_fixed_location = 1'b0;
   assign read_control_fixed_location  = 1'b0;
   assign write_control_write_base     = ADDRESSWIDTH'(AHB_BASE);
   assign read_control_read_base       = ADDRESSWIDTH'(AHB_BASE);
   assign write_data_size              = DSIZE;
   assign read_data_size               = DSIZE;
   assign write_user_write_buffer      = push;
   assign write_user_buffer_data       = data;
   assign read_user_read_buffer        = pop;
   assign status                       = DATAWIDTH'({busy, err_flags, state, idx});

   always_comb begin
      state_nx  = state;
      cmd_rd_en = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      abort     = (state inside {WR_GO, WR_FILL, WR_WAIT} && write_abort) ||
                  (state inside {RD_GO, RD_DATA} && read_abort);
      case (state)
         IDLE: begin
            cmd_rd_en = !cmd_empty;
            if (!cmd_empty && valid)
               state_nx = cmd.op == OP_WRITE ? WR_GO : cmd.op == OP_READ ? RD_GO : IDLE;
         end
         WR_GO:   state_nx = WR_FILL;
         WR_FILL: begin
            push = !write_user_buffer_full && left != 8'd0;
            if (left == 8'd0) state_nx = WR_WAIT;
         end
         WR_WAIT: if (write_control_done) state_nx = IDLE;
         RD_GO:   state_nx = RD_DATA;
         RD_DATA: begin
            pop = read_user_data_available && left != 8'd0;
            // done may precede the final pop, so it is remembered in done_seen
            if (left == 8'd0 && (done_seen || read_control_done)) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (abort) begin
         state_nx = IDLE;
         push     = 1'b0;
         pop      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state                      <= IDLE;
         left                       <= '0;
         idx                        <= '0;
         done_seen                  <= 1'b0;
         err_flags                  <= '0;
         data_addr                  <= ADDRESSWIDTH'(REG_BASE);
         write_control_go           <= 1'b0;
         read_control_go            <= 1'b0;
         write_control_write_length <= '0;
         read_control_read_length   <= '0;
      end else begin
         state            <= state_nx;
         // go is registered, landing two cycles after the pop cycle
         write_control_go <= state == WR_GO && !abort;
         read_control_go  <= state == RD_GO && !abort;
         if (cmd_rd_en) begin
            if (len_err) err_flags[ERR_LEN] <= 1'b1;
            if (bad_op)  err_flags[ERR_BADOP] <= 1'b1;
         end
         if (abort) err_flags[ERR_ABORT] <= 1'b1;
         if (accept && cmd.op == OP_WRITE) write_control_write_length <= ADDRESSWIDTH'(32'(cmd.len) * BPW);
         if (accept && cmd.op == OP_READ)  read_control_read_length  <= ADDRESSWIDTH'(32'(cmd.len) * BPW);
         if (accept) left <= cmd.len;
         else if (push || pop) left <= left - 8'd1;
         if (clr) idx <= '0;
         else if (pop) idx <= idx + IW'(1);
         if (state_nx == IDLE) done_seen <= 1'b0;
         else if (state inside {RD_GO, RD_DATA} && read_control_done) done_seen <= 1'b1;
         if (accept && cmd.op == OP_WRITE) data_addr <= ADDRESSWIDTH'(REG_BASE) + ADDRESSWIDTH'(cmd.offset);
         else if (push) data_addr <= data_addr + ADDRESSWIDTH'(1);
         else if (state != IDLE && state_nx == IDLE) data_addr <= ADDRESSWIDTH'(REG_BASE);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cap <= '{default: '0};
      else if (clr) cap <= '{default: '0};
      else if (pop) cap[idx] <= read_user_buffer_data;
   end

`ifdef XFER_STATS_EN
   logic [15:0] wr_cnt, rd_cnt, ab_cnt;
   logic        wr_evt, rd_evt;
   assign wr_evt = state == WR_WAIT && write_control_done && !abort;
   assign rd_evt = state == RD_DATA && state_nx == IDLE && !abort;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
         ab_cnt <= '0;
      end else if (clr) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
         ab_cnt <= '0;
      end else begin
         if (wr_evt && !(&wr_cnt)) wr_cnt <= wr_cnt + 16'd1;
         if (rd_evt && !(&rd_cnt)) rd_cnt <= rd_cnt + 16'd1;
         if (abort && !(&ab_cnt)) ab_cnt <= ab_cnt + 16'd1;
      end
   end

   always_comb
      display_data = disp_sel ? cap[disp_addr] :
                     disp_addr[1:0] == 2'd1 ? DATAWIDTH'(wr_cnt) :
                     disp_addr[1:0] == 2'd2 ? DATAWIDTH'(rd_cnt) :
                     disp_addr[1:0] == 2'd3 ? DATAWIDTH'(ab_cnt) : status;
`else
   assign display_data = disp_sel ? cap[disp_addr] : status;
`endif
endmodule

// File: tb/tb_ahb_cmd_sequencer.sv
// tb_ahb_cmd_sequencer: directed self-checking bench for ahb_cmd_sequencer with write/read scoreboards
module tb_ahb_cmd_sequencer;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic [31:0] data, data_addr, cmd_data = '0, display_data;
   logic        cmd_rd_en, cmd_empty = 1'b1, disp_sel = 1'b0;
   logic [4:0]  disp_addr = '0;
   logic        write_control_go, write_control_fixed_location;
   logic [31:0] write_control_write_base, write_control_write_length;
   logic [2:0]  write_data_size, read_data_size, err_flags;
   logic        write_control_done = 1'b0, write_abort = 1'b0, write_user_buffer_full = 1'b0;
   logic        write_user_write_buffer;
   logic [31:0] write_user_buffer_data;
   logic        read_control_go, read_control_fixed_location;
   logic [31:0] read_control_read_base, read_control_read_length;
   logic        read_control_done = 1'b0, read_abort = 1'b0, read_user_data_available = 1'b0;
   logic        read_user_read_buffer, busy;
   logic [31:0] read_user_buffer_data;

   int          n_checks = 0, n_fail = 0;
   int          n_push = 0, n_pop = 0, n_wgo = 0, n_rgo = 0, cyc = 0, pop_cyc = 0, wgo_cyc = 0;
   int          push_cyc[$];
   logic [31:0] wq[$], rq[$];
   logic [15:0] rd_seq = '0;
   logic        pop_seen = 1'b0;

   ahb_cmd_sequencer dut (
      .clk(clk), .reset_n(reset_n), .data(data), .data_addr(data_addr),
      .cmd_rd_en(cmd_rd_en), .cmd_data(cmd_data), .cmd_empty(cmd_empty),
      .disp_sel(disp_sel), .disp_addr(disp_addr), .display_data(display_data),
      .write_control_go(write_control_go), .write_control_fixed_location(write_control_fixed_location),
      .write_control_write_base(write_control_write_base), .write_control_write_length(write_control_write_length),
      .write_data_size(write_data_size), .write_control_done(write_control_done), .write_abort(write_abort),
      .write_user_write_buffer(write_user_write_buffer), .write_user_buffer_data(write_user_buffer_data),
      .write_user_buffer_full(write_user_buffer_full),
      .read_control_go(read_control_go), .read_control_fixed_location(read_control_fixed_location),
      .read_control_read_base(read_control_read_base), .read_control_read_length(read_control_read_length),
      .read_data_size(read_data_size), .read_control_done(read_control_done), .read_abort(read_abort),
      .read_user_read_buffer(read_user_read_buffer), .read_user_buffer_data(read_user_buffer_data),
      .read_user_data_available(read_user_data_available),
      .busy(busy), .err_flags(err_flags)
   );

   always #5 clk = ~clk;

   // register file returns a tagged copy of its address; read master streams a running sequence
   assign data                  = {16'hBEEF, data_addr[15:0]};
   assign read_user_buffer_data = {16'hD00D, rd_seq};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pop_seen) rd_seq <= rd_seq + 16'd1;
   end

   always @(negedge clk) begin
      pop_seen = read_user_read_buffer;
      if (cmd_rd_en) pop_cyc = cyc;
      if (write_control_go) begin n_wgo++; wgo_cyc = cyc; end
      if (read_control_go) n_rgo++;
      if (read_user_read_buffer) n_pop++;
      if (write_user_write_buffer) begin
         n_push++;
         push_cyc.push_back(cyc);
         chk("wr_push_expected", 32'(wq.size() != 0), 32'd1);
         if (wq.size() != 0) chk("wr_push_data", write_user_buffer_data, wq.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic show(input string tag, input logic sel, input int a, input logic [31:0] exp);
      disp_sel = sel;
      disp_addr = 5'(a);
      #1;
      chk(tag, display_data, exp);
   endtask

   task automatic issue(input logic [31:0] c);
      int t = 0;
      tick();
      cmd_data = c;
      cmd_empty = 1'b0;
      @(negedge clk);
      while (!cmd_rd_en && t < 100) begin @(negedge clk); t++; end
      chk("cmd_popped", 32'(cmd_rd_en), 32'd1);
      tick();
      cmd_empty = 1'b1;
   endtask

   task automatic run_write(input logic [31:0] c);
      int n = int'(c[23:16]);
      int off = int'(c[15:0]);
      int p0 = n_push;
      int t = 0;
      for (int i = 0; i < n; i++) wq.push_back({16'hBEEF, 16'(2 + off + i)});
      issue(c);
      while (n_push - p0 < n && t < 200) begin tick(); t++; end
      repeat (3) tick();
      write_control_done = 1'b1;
      tick();
      write_control_done = 1'b0;
      @(negedge clk);
      chk("wr_push_count", 32'(n_push - p0), 32'(n));
      chk("wr_idle", 32'(busy), 32'd0);
      chk("wr_addr_home", data_addr, 32'd2);
      chk("wr_queue_drained", 32'(wq.size()), 32'd0);
   endtask

   task automatic run_read(input logic [31:0] c);
      int n = int'(c[23:16]);
      int p0 = n_pop;
      int t = 0;
      issue(c);
      read_user_data_available = 1'b1;
      while (n_pop - p0 < n && t < 300) begin tick(); t++; end
      read_user_data_available = 1'b0;
      read_control_done = 1'b1;
      tick();
      read_control_done = 1'b0;
      tick();
      @(negedge clk);
      chk("rd_pop_count", 32'(n_pop - p0), 32'(n));
      chk("rd_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int p0, g0;
      logic [15:0] s0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", data_addr, 32'd2);
      chk("rst_err", 32'(err_flags), 32'd0);
      chk("rst_go", 32'({write_control_go, read_control_go}), 32'd0);
      chk("rst_strobes", 32'({write_user_write_buffer, read_user_read_buffer, cmd_rd_en}), 32'd0);
      chk("rst_sizes", 32'({write_data_size, read_data_size}), 32'({3'd2, 3'd2}));
      chk("rst_fixed", 32'({write_control_fixed_location, read_control_fixed_location}), 32'd0);
      show("rst_status", 1'b0, 0, 32'd0);
      show("rst_cap0", 1'b1, 0, 32'd0);
      tick();
      reset_n = 1'b1;

      p0 = push_cyc.size();
      run_write(32'hF0040005);
      chk("wr_go_latency", 32'(wgo_cyc - pop_cyc), 32'd2);
      chk("wr_go_count", 32'(n_wgo), 32'd1);
      chk("wr_push_back2back", 32'(push_cyc[p0 + 3] - push_cyc[p0]), 32'd3);
      chk("wr_length", write_control_write_length, 32'd16);
      chk("wr_base", write_control_write_base, 32'd0);

      s0 = rd_seq;
      p0 = n_pop;
      for (int j = 0; j < 3; j++) rq.push_back({16'hD00D, s0 + 16'(j)});
      issue(32'hDE030000);
      tick();
      read_user_data_available = 1'b1; tick();
      read_user_data_available = 1'b0; tick();
      read_user_data_available = 1'b1; tick();
      read_user_data_available = 1'b0; read_control_done = 1'b1; tick();
      read_control_done = 1'b0;
      @(negedge clk);
      chk("rd_early_done_busy", 32'(busy), 32'd1);
      chk("rd_early_done_pops", 32'(n_pop - p0), 32'd2);
      tick();
      read_user_data_available = 1'b1; tick();
      read_user_data_available = 1'b0; tick();
      @(negedge clk);
      chk("rd3_idle", 32'(busy), 32'd0);
      chk("rd3_pops", 32'(n_pop - p0), 32'd3);
      chk("rd3_go_count", 32'(n_rgo), 32'd1);
      chk("rd3_length", read_control_read_length, 32'd12);
      for (int j = 0; j < 3; j++) show($sformatf("rd3_cap%0d", j), 1'b1, j, rq.pop_front());
      show("rd3_status", 1'b0, 0, 32'h003);
`ifdef XFER_STATS_EN
      show("stat_wr", 1'b0, 1, 32'd1);
      show("stat_rd", 1'b0, 2, 32'd1);
      show("stat_ab", 1'b0, 3, 32'd0);
`endif

      issue(32'hC1010000);
      tick();
      for (int j = 0; j < 3; j++) show($sformatf("clr_cap%0d", j), 1'b1, j, 32'd0);
      show("clr_status", 1'b0, 0, 32'd0);
`ifdef XFER_STATS_EN
      show("clr_stat_wr", 1'b0, 1, 32'd0);
      show("clr_stat_rd", 1'b0, 2, 32'd0);
      show("clr_stat_ab", 1'b0, 3, 32'd0);
`endif

      s0 = rd_seq;
      run_read(32'hDE280000);
      show("wrap_cap0", 1'b1, 0, {16'hD00D, s0 + 16'd32});
      show("wrap_cap7", 1'b1, 7, {16'hD00D, s0 + 16'd39});
      show("wrap_cap8", 1'b1, 8, {16'hD00D, s0 + 16'd8});
      show("wrap_cap31", 1'b1, 31, {16'hD00D, s0 + 16'd31});
      show("wrap_status", 1'b0, 0, 32'h008);

      g0 = n_wgo;
      issue(32'hF0000000);
      @(negedge clk);
      chk("len0_err", 32'(err_flags), 32'b010);
      chk("len0_idle", 32'(busy), 32'd0);
      issue(32'hF0410000);
      @(negedge clk);
      chk("len65_err", 32'(err_flags), 32'b010);
      issue(32'h55010000);
      @(negedge clk);
      chk("badop_err", 32'(err_flags), 32'b011);
      show("badop_status", 1'b0, 0, 32'h308);
      repeat (3) tick();
      chk("err_no_go", 32'(n_wgo - g0), 32'd0);

      p0 = n_push;
      wq.push_back({16'hBEEF, 16'd2});
      wq.push_back({16'hBEEF, 16'd3});
      write_user_buffer_full = 1'b1;
      issue(32'hF0080000);
      tick();
      write_user_buffer_full = 1'b0;
      tick();
      tick();
      write_abort = 1'b1;
      tick();
      write_abort = 1'b0;
      @(negedge clk);
      chk("abort_idle", 32'(busy), 32'd0);
      chk("abort_err", 32'(err_flags), 32'b111);
      chk("abort_addr", data_addr, 32'd2);
      repeat (5) tick();
      chk("abort_pushes", 32'(n_push - p0), 32'd2);
      chk("abort_queue", 32'(wq.size()), 32'd0);
      run_write(32'hF0020001);
      show("final_status", 1'b0, 0, 32'h708);
`ifdef XFER_STATS_EN
      show("final_stat_wr", 1'b0, 1, 32'd1);
      show("final_stat_rd", 1'b0, 2, 32'd1);
      show("final_stat_ab", 1'b0, 3, 32'd1);
`endif

      write_user_buffer_full = 1'b1;
      issue(32'hF0030000);
      tick();
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_addr", data_addr, 32'd2);
      chk("midrst_err", 32'(err_flags), 32'd0);
      chk("midrst_go", 32'(write_control_go), 32'd0);
      show("midrst_cap0", 1'b1, 0, 32'd0);
      tick();
      reset_n = 1'b1;
      write_user_buffer_full = 1'b0;
      show("midrst_status", 1'b0, 0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ahb_cmd_sequencer.md
Name: ahb_cmd_sequencer

Overview:
Command-driven sequencer between the host command FIFO, the AHB slave register file, and the AHB write and read masters. It pops 32-bit command words and decodes opcode, word count and base offset. It then streams that many words from the register file into the write master, or drains that many words from the read master into a capture buffer. It handles aborts and length errors, and exposes the captured words on the display conduit.

Parameters:
- ADDRESSWIDTH, 32, AHB master address width
- DATAWIDTH, 32, data width; bytes/word BPW = DATAWIDTH/8
- NUMREGS, 32, capture buffer depth (power of 2)
- MAX_WORDS, 64, max words per command
- AHB_BASE, 32'h0, AHB base address for both masters
- REG_BASE, 32'h2, first register-file address polled

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- data  in  DATAWIDTH  register-file word at data_addr (same cycle)
- data_addr  out  ADDRESSWIDTH  register-file read address
- cmd_rd_en  out  1  pop command FIFO (show-ahead)
- cmd_data  in  32  head command word
- cmd_empty  in  1  command FIFO empty
- disp_sel  in  1  1: capture word, 0: status
- disp_addr  in  $clog2(NUMREGS)  capture index to display
- display_data  out  DATAWIDTH  display word
- write_control_go / _fixed_location / _write_base / _write_length, write_data_size  out  1/1/AW/AW/3
- write_control_done, write_abort  in  1 each
- write_user_write_buffer  out  1; write_user_buffer_data  out  DATAWIDTH; write_user_buffer_full  in  1
- read_control_go / _fixed_location / _read_base / _read_length, read_data_size  out  1/1/AW/AW/3
- read_control_done, read_abort  in  1 each
- read_user_read_buffer  out  1; read_user_buffer_data  in  DATAWIDTH; read_user_data_available  in  1
- busy  out  1  state != IDLE
- err_flags  out  3  sticky {abort, len_err, bad_op}

Behaviour:
- Command word: [31:24] opcode (8'hF0 WRITE, 8'hDE READ, 8'hC1 CLEAR), [23:16] word count N, [15:0] offset.
- Reset: state IDLE; all go/buffer strobes 0; data_addr=REG_BASE; capture regs, index and err_flags 0. fixed_location=0. Data sizes = log2(BPW) constant.
- IDLE: if !cmd_empty, assert cmd_rd_en for one cycle and latch the command. Decode in the same cycle.
  - N==0 or N>MAX_WORDS: set len_err, stay IDLE.
  - Unknown opcode: set bad_op, stay IDLE.
  - CLEAR: zero all capture regs and index next cycle, stay IDLE.
  - WRITE -> WR_GO, data_addr<=REG_BASE+offset. READ -> RD_GO.
- WR_GO (1 cycle): write_control_go=1, base=AHB_BASE, length=N*BPW (held for the whole command) -> WR_FILL.
- WR_FILL: write_user_write_buffer = !full && left>0. Each push: data_addr++, left--. When left==0 -> WR_WAIT. buffer_data = data, combinational.
- WR_WAIT: on write_control_done -> IDLE, data_addr<=REG_BASE.
- RD_GO (1 cycle): read_control_go=1, base=AHB_BASE, length=N*BPW -> RD_DATA.
- RD_DATA: read_user_read_buffer = data_available && left>0. Each pop: capture[index]<=buffer_data, index wraps mod NUMREGS, left--. Exit to IDLE only when left==0 and read_control_done; done may arrive before or after the last pop.
- Abort: write_abort in WR_* or read_abort in RD_* -> IDLE next cycle, set abort flag, no further strobes; data_addr<=REG_BASE.
- Latency: command visible -> go asserted = 2 cycles.
- display_data: disp_sel ? capture[disp_addr] : {status}, where status = busy, err_flags, state code, index (zero-extended).
- Reset mid-command: immediate return to reset values; the masters are reset by the same reset_n.

Optional Feature:
- XFER_STATS_EN defined: add 16-bit saturating counters for writes done, reads done and aborts. With disp_sel=0 and disp_addr[1:0]=1/2/3, display_data shows the respective counter. CLEAR also zeroes the counters.
- Undefined: no counters; status word only.

Decomposition:
- Package ahb_cmd_pkg: opcode localparams, state_t enum {IDLE, WR_GO, WR_FILL, WR_WAIT, RD_GO, RD_DATA}, cmd_t packed struct {op, len, offset}, err bit indices.
- One sub-module, cmd_decode: combinational cmd_data -> cmd_t plus valid/len_err/bad_op.

Test Plan:
- cmd 32'hF0040005, full never set -> go 2 cycles after pop, length=16, 4 pushes of reg words 7..10 on consecutive cycles; done -> IDLE, data_addr=2.
- cmd 32'hDE030000 with data_available toggling every other cycle -> exactly 3 pops, capture[0..2] hold the data, index=3; done before the last pop still exits only after 3 pops.
- 40-word READ with NUMREGS=32 -> index wraps, capture[0..7] hold words 32..39.
- cmd 32'hF0000000 and 32'hF0410000 (N=65) -> len_err set, no go, both popped; 32'h55010000 -> bad_op set.
- write_abort during WR_FILL after 2 of 8 pushes -> IDLE next cycle, abort flag set, no further pushes; the next command executes normally.
- CLEAR after a read -> capture regs 0, index 0; with XFER_STATS_EN, counters read 0.
